uart_tx_arbiter: RTL and testbench

Shares one `uart_tx` transmitter among N requesters (echo path, debug console, status reporter, …) by round-robin. Each accepted word is staged together with its per-requester frame configuration (data width, parity mode). The staged word is then handed to the transmitter over its `req_load`/`ack_load` handshake. The block sits between the requesters and `uart_tx` and runs on the same clock as the transmitter.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rr_pick.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: arbiter state encoding,
// parity mode constants, frame width limits and the config sanitising helpers
// used when a requester's word is captured.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    UART_ARB_IDLE = 2'd0,
    UART_ARB_HOLD = 2'd1,
    UART_ARB_LOAD = 2'd2
  } uart_arb_state_e;

  localparam logic [1:0] UART_PARITY_NONE = 2'd0;
  localparam logic [1:0] UART_PARITY_ODD  = 2'd1;
  localparam logic [1:0] UART_PARITY_EVEN = 2'd2;

  localparam logic [3:0] UART_WIDTH_DEFAULT = 4'd8;
  localparam logic [3:0] UART_WIDTH_MIN     = 4'd5;
  localparam logic [3:0] UART_WIDTH_MAX     = 4'd9;

  // Widths the transmitter cannot frame fall back to the default width.
  function automatic logic [3:0] uart_clamp_width(input logic [3:0] width);
    return (width < UART_WIDTH_MIN || width > UART_WIDTH_MAX) ? UART_WIDTH_DEFAULT : width;
  endfunction

  // Parity code 3 is unassigned and is treated as "no parity".
  function automatic logic [1:0] uart_clamp_parity(input logic [1:0] parity);
    return (parity == 2'd3) ? UART_PARITY_NONE : parity;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker: returns the first set bit of `valid`
// found by searching upward from position `start`, wrapping modulo N.
// Ports:
//   valid  [N]      candidate requesters
//   start  [PTR_W]  first position examined (must be < N)
//   onehot [N]      one-hot winner, all zero when nothing is valid
//   index  [PTR_W]  winner index, 0 when nothing is valid
//   any             at least one candidate was valid
// -----------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  int pos;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the loop leaves one unassigned and no latch is inferred.
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    pos    = 0;
    for (int k = 0; k < N; k++) begin
      // start < N and k < N, so a single subtraction performs the wrap.
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (!any && valid[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        index       = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx among N requesters by round-robin. The winning word is
// staged with its requester's frame config (width clamped to 5..9, parity
// code 3 mapped to none) and offered to the transmitter with a 4-phase
// tx_req_load / tx_ack_load handshake.
//
// Ports:
//   reset, clock              async active-low reset, rising-edge clock
//   req_valid/req_ready [N]   per-requester word handshake (ready is one-hot)
//   req_bits  [N*16]          packed words, slice i = [16i+15:16i]
//   cfg_width [N*4]           per-requester data width
//   cfg_parity[N*2]           per-requester parity mode
//   tx_req_load               transmitter ready for its next word (level)
//   tx_ack_load               staged word is valid and loaded
//   tx_bits/tx_width/tx_parity staged word and its frame config
//   grant_id  [PTR_W]         requester owning the staged word
//   busy                      a word is staged or being handed over
//
// Build option: define UART_TX_ARB_LOCK_EN to add the req_lock[N] input, which
// lets the last-granted requester keep the grant for multi-word messages.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             reset,
  input  logic             clock,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N-1:0]     req_lock,
`endif
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*16-1:0]  req_bits,
  input  logic [N*4-1:0]   cfg_width,
  input  logic [N*2-1:0]   cfg_parity,
  input  logic             tx_req_load,
  output logic             tx_ack_load,
  output logic [15:0]      tx_bits,
  output logic [3:0]       tx_width,
  output logic [1:0]       tx_parity,
  output logic [PTR_W-1:0] grant_id,
  output logic             busy
);

  uart_arb_state_e  state_q;
  logic [PTR_W-1:0] last_q;

  logic [N-1:0]     pick_valid;
  logic [PTR_W-1:0] pick_start;
  logic [N-1:0]     pick_onehot;
  logic [PTR_W-1:0] pick_index;
  logic             pick_any;

  logic [15:0]      win_bits;
  logic [3:0]       win_width;
  logic [1:0]       win_parity;

  // Candidate set and search origin: normally everyone, starting after the
  // previous winner; a held lock narrows the set to the previous winner alone.
  always_comb begin
    pick_valid = req_valid;
    pick_start = (int'(last_q) == N - 1) ? '0 : last_q + PTR_W'(1);
`ifdef UART_TX_ARB_LOCK_EN
    if (req_lock[last_q]) begin
      pick_valid         = '0;
      pick_valid[last_q] = req_valid[last_q];
      pick_start         = last_q;
    end
`endif
  end

  uart_rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid  (pick_valid),
    .start  (pick_start),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // Winner's word and sanitised frame config, selected by index.
  always_comb begin
    win_bits   = req_bits[int'(pick_index)*16 +: 16];
    win_width  = uart_clamp_width(cfg_width[int'(pick_index)*4 +: 4]);
    win_parity = uart_clamp_parity(cfg_parity[int'(pick_index)*2 +: 2]);
  end

  // Ready is gated by reset as well so nothing is offered while reset is held.
  assign req_ready = (reset && state_q == UART_ARB_IDLE) ? pick_onehot : '0;
  assign busy      = (state_q != UART_ARB_IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= UART_ARB_IDLE;
      last_q      <= PTR_W'(N - 1);
      tx_ack_load <= 1'b0;
      tx_bits     <= '0;
      tx_width    <= UART_WIDTH_DEFAULT;
      tx_parity   <= UART_PARITY_NONE;
      grant_id    <= '0;
    end else begin
      case (state_q)
        UART_ARB_IDLE: begin
          if (pick_any) begin
            tx_bits   <= win_bits;
            tx_width  <= win_width;
            tx_parity <= win_parity;
            grant_id  <= pick_index;
            last_q    <= pick_index;
            state_q   <= UART_ARB_HOLD;
          end
        end
        UART_ARB_HOLD: begin
          if (tx_req_load) begin
            tx_ack_load <= 1'b1;
            state_q     <= UART_ARB_LOAD;
          end
        end
        UART_ARB_LOAD: begin
          // Ack is held until the transmitter withdraws its request.
          if (!tx_req_load) begin
            tx_ack_load <= 1'b0;
            state_q     <= UART_ARB_IDLE;
          end
        end
        default: begin
          tx_ack_load <= 1'b0;
          state_q     <= UART_ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N = 4). A behavioural model tracks
// whether a word is staged / acknowledged and which requester was served last;
// outputs are compared against it every cycle, plus literal expectations for
// the directed scenarios. Lock scenario is built when UART_TX_ARB_LOCK_EN is set.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic        reset;
  logic        clock;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_bits;
  logic [15:0] cfg_width;
  logic [7:0]  cfg_parity;
  logic        tx_req_load;
  logic        tx_ack_load;
  logic [15:0] tx_bits;
  logic [3:0]  tx_width;
  logic [1:0]  tx_parity;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif

  uart_tx_arbiter #(.N(N)) dut (
    .reset       (reset),
    .clock       (clock),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bits    (req_bits),
    .cfg_width   (cfg_width),
    .cfg_parity  (cfg_parity),
    .tx_req_load (tx_req_load),
    .tx_ack_load (tx_ack_load),
    .tx_bits     (tx_bits),
    .tx_width    (tx_width),
    .tx_parity   (tx_parity),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: a word is "staged" from its accept until the transmitter drops
  // req_load after the ack; "acked" marks the ack phase.
  bit          m_staged;
  bit          m_acked;
  int          m_last;
  int          m_accept;
  logic [15:0] m_bits;
  logic [3:0]  m_width;
  logic [1:0]  m_parity;
  int          m_gid;

  bit recording;
  int dut_grants[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_staged = 0; m_acked = 0; m_last = N - 1; m_accept = -1;
    m_bits = 16'h0; m_width = 4'd8; m_parity = 2'd0; m_gid = 0;
  endtask

  // Next requester by round-robin from the one after the last winner.
  function automatic int model_pick();
`ifdef UART_TX_ARB_LOCK_EN
    if (req_lock[m_last]) return req_valid[m_last] ? m_last : -1;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    int w;
    r = '0;
    if (!m_staged) begin
      w = model_pick();
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_edge();
    int w, cw, cp;
    m_accept = -1;
    if (!m_staged) begin
      w = model_pick();
      if (w >= 0) begin
        cw = int'(cfg_width[w*4 +: 4]);
        cp = int'(cfg_parity[w*2 +: 2]);
        m_bits   = req_bits[w*16 +: 16];
        m_width  = (cw < 5 || cw > 9) ? 4'd8 : 4'(cw);
        m_parity = (cp == 3) ? 2'd0 : 2'(cp);
        m_gid    = w;
        m_last   = w;
        m_staged = 1;
        m_accept = w;
      end
    end else if (!m_acked) begin
      if (tx_req_load) m_acked = 1;
    end else if (!tx_req_load) begin
      m_acked  = 0;
      m_staged = 0;
    end
  endtask

  task automatic compare_model();
    check("ready",  req_ready,   model_ready());
    check("ack",    tx_ack_load, m_acked);
    check("busy",   busy,        m_staged);
    check("bits",   tx_bits,     m_bits);
    check("width",  tx_width,    m_width);
    check("parity", tx_parity,   m_parity);
    check("gid",    grant_id,    m_gid);
  endtask

  // One clock cycle: inputs were set at the preceding negedge by the caller.
  task automatic cycle();
    #1;
    compare_model();
    if (recording && req_ready != 4'b0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    tx_req_load = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(negedge clock);
    model_reset();
    check("rst_ready",  req_ready,   4'b0);
    check("rst_ack",    tx_ack_load, 1'b0);
    check("rst_bits",   tx_bits,     16'h0);
    check("rst_width",  tx_width,    4'd8);
    check("rst_parity", tx_parity,   2'd0);
    check("rst_gid",    grant_id,    2'd0);
    check("rst_busy",   busy,        1'b0);
    reset = 1'b1;
  endtask

  task automatic new_word(input int i, input bit wild_cfg);
    req_bits[i*16 +: 16] = 16'($urandom);
    cfg_width[i*4 +: 4]  = wild_cfg ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 9));
    cfg_parity[i*2 +: 2] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_bits = '0;
    cfg_width = {4{4'd8}};
    cfg_parity = '0;
    tx_req_load = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = '0;
`endif
    model_reset();
    recording = 0;

    // Single request, then handshake hold with another requester waiting.
    apply_reset();
    req_valid = 4'b0100;
    req_bits[2*16 +: 16] = 16'h00A5;
    cfg_width[2*4 +: 4] = 4'd8;
    cfg_parity[2*2 +: 2] = 2'd0;
    tx_req_load = 1'b1;
    #1 check("single_ready", req_ready, 4'b0100);
    cycle();
    req_valid = 4'b0000;
    check("single_bits", tx_bits, 16'h00A5);
    check("single_gid",  grant_id, 2'd2);
    check("single_busy", busy, 1'b1);
    check("single_ack0", tx_ack_load, 1'b0);
    cycle();
    check("single_ack1", tx_ack_load, 1'b1);
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("hold_ack", tx_ack_load, 1'b1);
      check("hold_bits", tx_bits, 16'h00A5);
    end
    tx_req_load = 1'b0;
    cycle();
    check("release_ack", tx_ack_load, 1'b0);
    check("next_ready", req_ready, 4'b0001);
    cycle();
    req_valid = 4'b0000;
    check("next_gid", grant_id, 2'd0);
    repeat (3) cycle();

    // Fairness: all requesters valid, tx_req_load toggling each cycle.
    apply_reset();
    for (int i = 0; i < N; i++) new_word(i, 0);
    req_valid = 4'b1111;
    dut_grants.delete();
    recording = 1;
    for (int c = 0; c < 100 && dut_grants.size() < 8; c++) begin
      cycle();
      tx_req_load = ~tx_req_load;
      if (m_accept >= 0) new_word(m_accept, 0);
    end
    recording = 0;
    check("fair_count", dut_grants.size(), 8);
    for (int g = 0; g < dut_grants.size() && g < 8; g++) check("fair_order", dut_grants[g], g % 4);

    // Config clamp on capture.
    apply_reset();
    req_valid = 4'b1000;
    req_bits[3*16 +: 16] = 16'h1234;
    cfg_width[3*4 +: 4] = 4'd12;
    cfg_parity[3*2 +: 2] = 2'd3;
    cycle();
    req_valid = 4'b0000;
    check("clamp_width",  tx_width,  4'd8);
    check("clamp_parity", tx_parity, 2'd0);
    check("clamp_gid",    grant_id,  2'd3);

    // Reset while in the ack phase.
    apply_reset();
    req_valid = 4'b0010;
    tx_req_load = 1'b1;
    cycle();
    req_valid = 4'b0000;
    cycle();
    check("rl_ack_before", tx_ack_load, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rl_ack", tx_ack_load, 1'b0);
    check("rl_busy", busy, 1'b0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = 4'b1111;
    tx_req_load = 1'b0;
    #1 check("rl_first_ready", req_ready, 4'b0001);
    cycle();
    check("rl_first_gid", grant_id, 2'd0);
    req_valid = 4'b0000;
    tx_req_load = 1'b1;
    repeat (2) cycle();
    tx_req_load = 1'b0;
    cycle();

`ifdef UART_TX_ARB_LOCK_EN
    // Lock keeps requester 1 for three words, then requester 2 is served.
    begin
      int n1;
      n1 = 0;
      apply_reset();
      new_word(1, 0);
      new_word(2, 0);
      req_lock = 4'b0010;
      req_valid = 4'b0110;
      dut_grants.delete();
      recording = 1;
      for (int c = 0; c < 100 && dut_grants.size() < 4; c++) begin
        cycle();
        tx_req_load = ~tx_req_load;
        if (m_accept == 1) begin
          n1++;
          new_word(1, 0);
          if (n1 == 3) begin
            req_lock = 4'b0000;
            req_valid[1] = 1'b0;
          end
        end
        if (m_accept == 2) req_valid[2] = 1'b0;
      end
      recording = 0;
      check("lock_count", dut_grants.size(), 4);
      for (int g = 0; g < dut_grants.size() && g < 4; g++)
        check("lock_order", dut_grants[g], (g < 3) ? 1 : 2);
    end
`endif

    // Randomised traffic against the model.
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_accept == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom % 4 == 0)) begin
          new_word(i, ($urandom % 4) == 0);
          req_valid[i] = 1'b1;
        end
      end
      tx_req_load = 1'($urandom % 2);
`ifdef UART_TX_ARB_LOCK_EN
      req_lock = ($urandom % 8 == 0) ? 4'($urandom) : 4'b0;
`endif
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d comparisons failed", fails, tests);
    $fatal(1, "watchdog");
  end

endmodule
